// File: rtl/regfile_golden_checker.sv
// End-of-test register-file checker: waits for a sentinel value (or a timeout),
// snapshots the architectural registers and compares them against a golden ROM.
module regfile_golden_checker #(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     NREGS          = 32,
    parameter int unsigned     IDX_W          = 5,
    parameter int unsigned     SENTINEL_REG   = 11,
    parameter logic [XLEN-1:0] SENTINEL_VAL   = XLEN'(32'h0000C0DE),
    parameter int unsigned     TIMEOUT        = 50,
    parameter int unsigned     TO_W           = 16,
    parameter bit              STRICT_TIMEOUT = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NREGS*XLEN-1:0] i_regs_flat,
    output logic                  o_gold_rd_en,
    output logic [IDX_W-1:0]      o_gold_addr,
    input  logic [XLEN-1:0]       i_gold_data,
    input  logic                  i_gold_skip,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [IDX_W:0]        o_mismatch_cnt,
    output logic [IDX_W-1:0]      o_first_mis_idx,
    output logic [XLEN-1:0]       o_first_mis_exp,
    output logic [XLEN-1:0]       o_first_mis_act
);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSent,
        StFetch,
        StCmp,
        StDone
    } state_e;

    state_e            r_state;
    logic [XLEN-1:0]   r_snap [NREGS];
    logic [TO_W-1:0]   r_to_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_gold_rd_en;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic [IDX_W:0]    r_mis_cnt;
    logic [IDX_W-1:0]  r_first_idx;
    logic [XLEN-1:0]   r_first_exp;
    logic [XLEN-1:0]   r_first_act;

    logic              w_sent_hit;
    logic              w_is_mis;
    logic [IDX_W:0]    w_mis_cnt_nxt;
    logic              w_pass_nxt;

    // Sentinel detect, per-entry compare and final verdict for the last entry
    always_comb begin
        w_sent_hit    = (i_regs_flat[SENTINEL_REG*XLEN +: XLEN] == SENTINEL_VAL);
        w_is_mis      = !i_gold_skip && (i_gold_data != r_snap[r_idx]);
        w_mis_cnt_nxt = r_mis_cnt + {{IDX_W{1'b0}}, w_is_mis};
        w_pass_nxt    = (w_mis_cnt_nxt == '0) && !(r_timeout && STRICT_TIMEOUT);
    end

    // Checker FSM with all outputs registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_to_cnt     <= '0;
            r_idx        <= '0;
            r_gold_rd_en <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_mis_cnt    <= '0;
            r_first_idx  <= '0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state     <= StWaitSent;
                        r_to_cnt    <= '0;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_mis_cnt   <= '0;
                        r_first_idx <= '0;
                        r_first_exp <= '0;
                        r_first_act <= '0;
                    end
                end
                StWaitSent: begin
                    // Sentinel has priority over a timeout landing in the same cycle
                    if (w_sent_hit || (r_to_cnt == TO_LAST)) begin
                        r_timeout    <= !w_sent_hit;
                        r_state      <= StFetch;
                        r_gold_rd_en <= 1'b1;
                        r_idx        <= '0;
                        for (int i = 0; i < int'(NREGS); i++) begin
                            r_snap[i] <= i_regs_flat[i*XLEN +: XLEN];
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                StFetch: begin
                    r_gold_rd_en <= 1'b0;
                    r_state      <= StCmp;
                end
                StCmp: begin
                    if (w_is_mis) begin
                        r_mis_cnt <= w_mis_cnt_nxt;
                        if (r_mis_cnt == '0) begin
                            r_first_idx <= r_idx;
                            r_first_exp <= i_gold_data;
                            r_first_act <= r_snap[r_idx];
                        end
                    end
                    if (r_idx == IDX_LAST) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= w_pass_nxt;
                    end else begin
                        r_idx        <= r_idx + 1'b1;
                        r_state      <= StFetch;
                        r_gold_rd_en <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_gold_rd_en    = r_gold_rd_en;
    assign o_gold_addr     = r_idx;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_timeout       = r_timeout;
    assign o_mismatch_cnt  = r_mis_cnt;
    assign o_first_mis_idx = r_first_idx;
    assign o_first_mis_exp = r_first_exp;
    assign o_first_mis_act = r_first_act;

endmodule

// File: tb/tb_regfile_golden_checker.sv
// Directed bench for regfile_golden_checker: strict and non-strict instances in lockstep.
module tb_regfile_golden_checker;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [NREGS*XLEN-1:0] regs_flat;
    logic [XLEN-1:0]       gold_data;
    logic                  gold_skip;

    logic [XLEN-1:0]       gold_mem [NREGS];
    logic                  skip_mem [NREGS];

    logic                  gold_rd_en, busy, done, pass, timeout;
    logic [4:0]            gold_addr, first_mis_idx;
    logic [5:0]            mismatch_cnt;
    logic [XLEN-1:0]       first_mis_exp, first_mis_act;

    logic                  ns_rd_en, ns_busy, ns_done, ns_pass, ns_timeout;
    logic [4:0]            ns_addr, ns_first_idx;
    logic [5:0]            ns_mis_cnt;
    logic [XLEN-1:0]       ns_first_exp, ns_first_act;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    regfile_golden_checker #(.STRICT_TIMEOUT(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_regs_flat(regs_flat),
        .o_gold_rd_en(gold_rd_en), .o_gold_addr(gold_addr),
        .i_gold_data(gold_data), .i_gold_skip(gold_skip),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(timeout),
        .o_mismatch_cnt(mismatch_cnt), .o_first_mis_idx(first_mis_idx),
        .o_first_mis_exp(first_mis_exp), .o_first_mis_act(first_mis_act)
    );

    regfile_golden_checker #(.STRICT_TIMEOUT(1'b0)) dut_ns (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_regs_flat(regs_flat),
        .o_gold_rd_en(ns_rd_en), .o_gold_addr(ns_addr),
        .i_gold_data(gold_data), .i_gold_skip(gold_skip),
        .o_busy(ns_busy), .o_done(ns_done), .o_pass(ns_pass), .o_timeout(ns_timeout),
        .o_mismatch_cnt(ns_mis_cnt), .o_first_mis_idx(ns_first_idx),
        .o_first_mis_exp(ns_first_exp), .o_first_mis_act(ns_first_act)
    );

    // Golden ROM model: one-cycle read latency
    always @(posedge clk) begin
        if (gold_rd_en) begin
            gold_data <= gold_mem[gold_addr];
            gold_skip <= skip_mem[gold_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input int i, input logic [XLEN-1:0] v);
        regs_flat[i*XLEN +: XLEN] = v;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        regs_flat = '0;
        gold_data = '0;
        gold_skip = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            set_reg(i, 32'h1000_0000 + i);
            gold_mem[i] = 32'h1000_0000 + i;
            skip_mem[i] = 1'b0;
        end
        gold_mem[11] = 32'h0000_C0DE;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_rd_en", gold_rd_en, 0);
        check("rst_addr", gold_addr, 0);
        check("rst_mis_cnt", mismatch_cnt, 0);
        check("rst_first", {first_mis_idx, first_mis_exp, first_mis_act}, 0);

        // 1: sentinel written in cycle 6, done in cycle 71; start mid-compare ignored
        arm();
        check("t1_busy", busy, 1);
        check("t1_done0", done, 0);
        repeat (5) tick();
        set_reg(11, 32'h0000_C0DE);
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("t1_latency", n + 11, 65);
        check("t1_pass", pass, 1);
        check("t1_mis_cnt", mismatch_cnt, 0);
        check("t1_timeout", timeout, 0);
        check("t1_busy_end", busy, 0);
        check("t1_ns_pass", ns_pass, 1);

        // 2: two mismatches, re-armed from DONE; sentinel already present
        gold_mem[3] = 32'h0000_0005;
        set_reg(3, 32'h0000_0004);
        gold_mem[7] = 32'hFFFF_FFFF;
        set_reg(7, 32'h0000_0000);
        arm();
        check("t2_done_cleared", done, 0);
        wait_done(n);
        check("t2_latency", n, 65);
        check("t2_mis_cnt", mismatch_cnt, 2);
        check("t2_first_idx", first_mis_idx, 3);
        check("t2_first_exp", first_mis_exp, 32'h0000_0005);
        check("t2_first_act", first_mis_act, 32'h0000_0004);
        check("t2_pass", pass, 0);
        check("t2_ns_pass", ns_pass, 0);

        // 3: timeout, registers match golden
        gold_mem[3] = 32'h0000_0004;
        gold_mem[7] = 32'h0000_0000;
        set_reg(11, 32'h0000_0000);
        gold_mem[11] = 32'h0000_0000;
        arm();
        check("t3_cleared_cnt", mismatch_cnt, 0);
        check("t3_cleared_first", {first_mis_idx, first_mis_exp, first_mis_act}, 0);
        repeat (49) tick();
        check("t3_timeout_c50", timeout, 0);
        tick();
        check("t3_timeout_c51", timeout, 1);
        check("t3_rd_en_c51", gold_rd_en, 1);
        wait_done(n);
        check("t3_latency", n, 64);
        check("t3_mis_cnt", mismatch_cnt, 0);
        check("t3_strict_pass", pass, 0);
        check("t3_ns_pass", ns_pass, 1);
        check("t3_ns_timeout", ns_timeout, 1);

        // 4: skipped entry mismatching
        set_reg(11, 32'h0000_C0DE);
        gold_mem[11] = 32'h0000_C0DE;
        set_reg(5, 32'h0000_0055);
        skip_mem[5] = 1'b1;
        arm();
        wait_done(n);
        check("t4_mis_cnt", mismatch_cnt, 0);
        check("t4_pass", pass, 1);

        // 5: snapshot isolation from later register changes
        skip_mem[5] = 1'b0;
        set_reg(5, gold_mem[5]);
        set_reg(11, 32'h0000_0000);
        arm();
        repeat (3) tick();
        set_reg(11, 32'h0000_C0DE);
        tick();
        for (int i = 0; i < NREGS; i++) set_reg(i, 32'hDEAD_BEEF);
        wait_done(n);
        check("t5_latency", n + 1, 65);
        check("t5_mis_cnt", mismatch_cnt, 0);
        check("t5_pass", pass, 1);

        // 5b: sentinel in the same cycle as the last timeout cycle
        for (int i = 0; i < NREGS; i++) set_reg(i, gold_mem[i]);
        set_reg(11, 32'h0000_0000);
        arm();
        repeat (49) tick();
        set_reg(11, 32'h0000_C0DE);
        tick();
        check("t5b_timeout", timeout, 0);
        check("t5b_busy", busy, 1);
        wait_done(n);
        check("t5b_latency", n, 64);
        check("t5b_pass", pass, 1);

        // 6: reset during CMP at idx 10, after a mismatch at x3
        gold_mem[3] = 32'h0000_0005;
        arm();
        repeat (21) tick();
        check("t6_fetch_rd_en", gold_rd_en, 1);
        check("t6_fetch_addr", gold_addr, 10);
        tick();
        check("t6_cmp_rd_en", gold_rd_en, 0);
        check("t6_cmp_mis_cnt", mismatch_cnt, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_flags", {busy, done, pass, timeout, gold_rd_en}, 0);
        check("t6_rst_addr", gold_addr, 0);
        check("t6_rst_mis_cnt", mismatch_cnt, 0);
        check("t6_rst_first", {first_mis_idx, first_mis_exp, first_mis_act}, 0);
        repeat (3) tick();
        check("t6_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_golden_checker.md
Name: regfile_golden_checker

Overview:
- Synthesizable, parametrised end-of-test checker for the pipelined CPU core.
- Arms on `start` and waits for a sentinel register to reach a magic value, or for a cycle timeout.
- Then snapshots the whole architectural register file and compares it, one entry at a time, against a golden ROM.
- Reports pass/fail, timeout, mismatch count and first-mismatch details; sits beside `cpu_top` on the register-file debug outputs, for FPGA self-check and simulation alike.

Parameters:
- XLEN, 32, register width.
- NREGS, 32, number of registers checked (indices 0..NREGS-1).
- IDX_W, 5, index width; must satisfy 2^IDX_W >= NREGS.
- SENTINEL_REG, 11, index of the register watched for completion.
- SENTINEL_VAL, 32'h0000C0DE, completion value (XLEN bits).
- TIMEOUT, 50, cycles to wait for the sentinel; must be >= 1.
- TO_W, 16, timeout counter width; must hold TIMEOUT.
- STRICT_TIMEOUT, 1, 1 = a timeout forces pass=0; 0 = pass depends on the comparison only.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  arm pulse; honoured in IDLE or DONE only.
- regs_flat  in  NREGS*XLEN  live register file; register i at bits [i*XLEN +: XLEN].
- gold_rd_en  out  1  golden ROM read strobe.
- gold_addr  out  IDX_W  golden ROM index.
- gold_data  in  XLEN  golden value; valid exactly 1 cycle after gold_rd_en.
- gold_skip  in  1  golden entry is blank/comment; sampled with gold_data.
- busy  out  1  high in WAIT_SENT, FETCH, CMP.
- done  out  1  high in DONE.
- pass  out  1  result; meaningful only while done=1.
- timeout  out  1  sentinel not seen within TIMEOUT cycles.
- mismatch_cnt  out  IDX_W+1  number of non-skipped mismatches.
- first_mis_idx  out  IDX_W  index of the first mismatch.
- first_mis_exp  out  XLEN  golden value at the first mismatch.
- first_mis_act  out  XLEN  snapshot value at the first mismatch.

Behaviour:
- Single clock `clk`; `rst` is synchronous, active-high.
- On reset: state=IDLE; gold_rd_en, gold_addr, busy, done, pass, timeout, mismatch_cnt and all first_mis_* are 0; snapshot and counters are 0.
- Reset mid-operation aborts immediately at the next edge, with no partial results kept.
- IDLE: `start` -> WAIT_SENT.
  - Clear to_cnt, idx, mismatch_cnt, first_mis_*, timeout, pass.
- WAIT_SENT: each cycle, check `regs_flat[SENTINEL_REG] == SENTINEL_VAL`.
  - If equal: snapshot all regs, go to FETCH with idx=0.
  - Else if to_cnt == TIMEOUT-1: set timeout=1, snapshot, go to FETCH.
  - Else: to_cnt++.
  - Sentinel match and timeout in the same cycle: sentinel wins, timeout stays 0.
- FETCH: gold_rd_en=1, gold_addr=idx -> CMP. gold_rd_en is low in every other state.
- CMP: compare gold_data against snapshot[idx].
  - If gold_skip=1: the entry is ignored.
  - Else on mismatch: mismatch_cnt++. If mismatch_cnt was 0, latch first_mis_idx/exp/act.
  - Then: idx==NREGS-1 -> DONE, else idx++ -> FETCH.
- Comparison is bitwise and exact. Register 0 is compared like any other.
- DONE: done=1, busy=0.
  - pass = (mismatch_cnt==0) && !(timeout && STRICT_TIMEOUT); registered on DONE entry.
  - Results hold until `start` (re-arm directly into WAIT_SENT with results cleared) or rst.
- `start` in WAIT_SENT/FETCH/CMP is ignored.
- The snapshot is taken once. Later changes on regs_flat do not affect the result.
- Latency: start sampled at edge 0 -> WAIT_SENT from cycle 1.
  - Trigger in cycle k -> FETCH in k+1 -> done=1 in cycle k+1+2*NREGS.
- mismatch_cnt max is NREGS and cannot overflow.

Test Plan:
1. Sentinel: x11 set to 0000C0DE in cycle 6 after arm; golden equals regs -> done at cycle 71 (NREGS=32), pass=1, mismatch_cnt=0, timeout=0.
2. Mismatches: golden x3=00000005 vs actual 00000004, golden x7=FFFFFFFF vs actual 0 -> mismatch_cnt=2, first_mis_idx=3, first_mis_exp=00000005, first_mis_act=00000004, pass=0.
3. Timeout: sentinel never written, TIMEOUT=50 -> timeout=1 after 50 WAIT_SENT cycles, compare still runs.
   - Regs match: STRICT_TIMEOUT=1 gives pass=0; STRICT_TIMEOUT=0 gives pass=1.
4. Skip: gold_skip=1 on x5 whose value mismatches, all others match -> mismatch_cnt=0, pass=1.
5. Snapshot: after the sentinel triggers, drive all regs_flat to DEADBEEF -> result still reflects the snapshot (pass=1 with a matching golden).
   - Sentinel match in the same cycle as to_cnt==TIMEOUT-1 -> timeout=0.
6. Control: rst asserted during CMP at idx=10 -> next cycle all outputs 0, state IDLE.
   - start during busy is ignored.
   - start in DONE clears the results and rechecks correctly.
